uart_reg_writer: RTL

- Serial command front-end that drives the output setting register bank.
- Receives 8N1 UART frames on RXD and decodes register-write commands.
- Generates the bank's CS, WE, addr, data and write_data_strob sequence.
- Sits directly upstream of the register bank; its outputs connect 1:1 to the bank's write-side inputs.

---
 rtl/uart_reg_writer.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_reg_writer.sv
// UART (8N1) command receiver driving register-bank write cycles.
// Optional checksum byte enabled by defining UART_REG_WRITER_CSUM_EN.
module uart_reg_writer #(
    parameter int CLK_DIV      = 16,
    parameter int ADDR_MAX     = 0,
    parameter int STROBE_LEN   = 2,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic       CLK,
    input  logic       CLEAR,
    input  logic       RXD,
    output logic       write_data_strob,
    output logic [3:0] addr,
    output logic [7:0] data_out,
    output logic       WE,
    output logic       CS,
    output logic       frame_err,
    output logic       busy
);
    localparam int TMO = TIMEOUT_BITS * CLK_DIV;
    localparam int CW  = $clog2(CLK_DIV);
    localparam int TW  = $clog2(TMO + 1);
    localparam int SW  = (STROBE_LEN > 1) ? $clog2(STROBE_LEN) : 1;
    localparam logic [CW-1:0] HALF_M1 = CW'(CLK_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLK_DIV - 1);
    localparam logic [TW-1:0] TMO_M1  = TW'(TMO - 1);
    localparam logic [SW-1:0] STB_M1  = SW'(STROBE_LEN - 1);
    localparam logic [7:0]    HDR     = 8'hA5;
    localparam logic [7:0]    AMAX    = 8'(ADDR_MAX);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_e;
    typedef enum logic [2:0] {
        P_WAIT_HDR,
        P_GET_ADDR,
        P_GET_DATA,
`ifdef UART_REG_WRITER_CSUM_EN
        P_GET_CSUM,
`endif
        P_SETUP,
        P_STROBE,
        P_HOLD
    } p_state_e;

    logic          sync1_q, sync2_q, prev_q;
    rx_state_e     rs_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic          rx_valid_q, rx_ferr_q;

    always_ff @(posedge CLK or posedge CLEAR) begin
        if (CLEAR) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            prev_q     <= 1'b1;
            rs_q       <= R_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            rx_valid_q <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            sync1_q    <= RXD;
            sync2_q    <= sync1_q;
            prev_q     <= sync2_q;
            rx_valid_q <= 1'b0;
            rx_ferr_q  <= 1'b0;
            case (rs_q)
                R_IDLE: begin
                    cnt_q <= '0;
                    if (prev_q && !sync2_q) rs_q <= R_START;
                end
                R_START: begin
                    if (cnt_q == HALF_M1) begin
                        cnt_q <= '0;
                        bit_q <= '0;
                        rs_q  <= sync2_q ? R_IDLE : R_DATA;
                    end else cnt_q <= cnt_q + 1'b1;
                end
                R_DATA: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_q   <= '0;
                        shift_q <= {sync2_q, shift_q[7:1]};
                        if (bit_q == 3'd7) rs_q <= R_STOP;
                        else bit_q <= bit_q + 1'b1;
                    end else cnt_q <= cnt_q + 1'b1;
                end
                default: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_q      <= '0;
                        rs_q       <= R_IDLE;
                        rx_valid_q <= sync2_q;
                        rx_ferr_q  <= !sync2_q;
                    end else cnt_q <= cnt_q + 1'b1;
                end
            endcase
        end
    end

    p_state_e      ps_q;
    logic [7:0]    buf_q;
    logic          full_q;
    logic [TW-1:0] tmo_q;
    logic [SW-1:0] scnt_q;
    logic [3:0]    abuf_q;
`ifdef UART_REG_WRITER_CSUM_EN
    logic [7:0]    dbuf_q;
`endif
    logic          strob_q, cs_q, we_q, ferr_q, busy_q;
    logic [3:0]    addr_q;
    logic [7:0]    data_q;

    logic       in_write, in_get, in_valid, use_buf, abort, addr_ok;
    logic [7:0] in_byte;

    always_comb begin
        in_write = (ps_q == P_SETUP) || (ps_q == P_STROBE) || (ps_q == P_HOLD);
        in_get   = !in_write && (ps_q != P_WAIT_HDR);
        in_valid = 1'b0;
        use_buf  = 1'b0;
        in_byte  = shift_q;
        if (in_write) begin
            in_valid = 1'b0;
        end else if (ps_q == P_WAIT_HDR && full_q) begin
            in_valid = 1'b1;
            use_buf  = 1'b1;
            in_byte  = buf_q;
        end else begin
            in_valid = rx_valid_q;
        end
        abort   = in_get && !in_valid && (rx_ferr_q || tmo_q == TMO_M1);
        addr_ok = (in_byte[7:4] == 4'h0) && (in_byte <= AMAX);
    end

    always_ff @(posedge CLK or posedge CLEAR) begin
        if (CLEAR) begin
            ps_q    <= P_WAIT_HDR;
            buf_q   <= '0;
            full_q  <= 1'b0;
            tmo_q   <= '0;
            scnt_q  <= '0;
            abuf_q  <= '0;
`ifdef UART_REG_WRITER_CSUM_EN
            dbuf_q  <= '0;
`endif
            strob_q <= 1'b0;
            cs_q    <= 1'b1;
            we_q    <= 1'b1;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            ferr_q <= rx_ferr_q;
            tmo_q  <= in_get ? tmo_q + 1'b1 : '0;
            // One-deep holding register for bytes landing mid-write
            if (in_write && rx_valid_q) begin
                buf_q  <= shift_q;
                full_q <= 1'b1;
            end else if (use_buf) begin
                full_q <= rx_valid_q;
                if (rx_valid_q) buf_q <= shift_q;
            end
            case (ps_q)
                P_WAIT_HDR: begin
                    if (in_valid && in_byte == HDR) begin
                        ps_q   <= P_GET_ADDR;
                        busy_q <= 1'b1;
                    end
                end
                P_GET_ADDR: begin
                    if (in_valid) begin
                        tmo_q <= '0;
                        if (addr_ok) begin
                            abuf_q <= in_byte[3:0];
                            ps_q   <= P_GET_DATA;
                        end else begin
                            ferr_q <= 1'b1;
                            busy_q <= 1'b0;
                            ps_q   <= P_WAIT_HDR;
                        end
                    end
                end
                P_GET_DATA: begin
                    if (in_valid) begin
                        tmo_q <= '0;
`ifdef UART_REG_WRITER_CSUM_EN
                        dbuf_q <= in_byte;
                        ps_q   <= P_GET_CSUM;
`else
                        addr_q <= abuf_q;
                        data_q <= in_byte;
                        cs_q   <= 1'b0;
                        we_q   <= 1'b0;
                        ps_q   <= P_SETUP;
`endif
                    end
                end
`ifdef UART_REG_WRITER_CSUM_EN
                P_GET_CSUM: begin
                    if (in_valid) begin
                        tmo_q <= '0;
                        if (in_byte == (HDR ^ {4'h0, abuf_q} ^ dbuf_q)) begin
                            addr_q <= abuf_q;
                            data_q <= dbuf_q;
                            cs_q   <= 1'b0;
                            we_q   <= 1'b0;
                            ps_q   <= P_SETUP;
                        end else begin
                            ferr_q <= 1'b1;
                            busy_q <= 1'b0;
                            ps_q   <= P_WAIT_HDR;
                        end
                    end
                end
`endif
                P_SETUP: begin
                    strob_q <= 1'b1;
                    scnt_q  <= '0;
                    ps_q    <= P_STROBE;
                end
                P_STROBE: begin
                    if (scnt_q == STB_M1) begin
                        strob_q <= 1'b0;
                        ps_q    <= P_HOLD;
                    end else scnt_q <= scnt_q + 1'b1;
                end
                default: begin
                    cs_q   <= 1'b1;
                    we_q   <= 1'b1;
                    busy_q <= 1'b0;
                    ps_q   <= P_WAIT_HDR;
                end
            endcase
            if (abort) begin
                ferr_q <= 1'b1;
                busy_q <= 1'b0;
                ps_q   <= P_WAIT_HDR;
            end
        end
    end

    assign write_data_strob = strob_q;
    assign addr             = addr_q;
    assign data_out         = data_q;
    assign WE               = we_q;
    assign CS               = cs_q;
    assign frame_err        = ferr_q;
    assign busy             = busy_q;
endmodule
